// File: rtl/rob_multi_pkg.sv
// rob_multi_pkg: default sizing for the reorder buffer and a small shared helper.
package rob_multi_pkg;

   localparam int ROB_DEPTH_DEF = 64;
   localparam int DISP_W_DEF    = 2;
   localparam int RET_W_DEF     = 2;
   localparam int CDB_W_DEF     = 6;
   localparam int PR_W_DEF      = 7;

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/rob_cdb_match.sv
// rob_cdb_match: compares every pending ROB entry tag against all CDB channels and
// produces one set-ready bit per entry; several channels may hit the same entry.
module rob_cdb_match #(
   parameter int ROB_DEPTH = 64,
   parameter int CDB_W     = 6,
   parameter int PR_W      = 7
) (
   input  logic [ROB_DEPTH-1:0]      pend_i,
   input  logic [ROB_DEPTH*PR_W-1:0] tag_i,
   input  logic [CDB_W-1:0]          cdb_valid_i,
   input  logic [CDB_W*PR_W-1:0]     cdb_tag_i,
   output logic [ROB_DEPTH-1:0]      set_ready_o
);

   always_comb begin
      set_ready_o = '0;
      for (int e = 0; e < ROB_DEPTH; e++) begin
         for (int c = 0; c < CDB_W; c++) begin
            if (pend_i[e] && cdb_valid_i[c] &&
                (tag_i[e*PR_W +: PR_W] == cdb_tag_i[c*PR_W +: PR_W])) begin
               set_ready_o[e] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rob_multi.sv
// rob_multi: parametrised reorder buffer between dispatch, the CDB and the free list / arch map.
// Optional full-pipeline squash (ex_squash port) is compiled in with `define ROB_SQUASH_EN.
module rob_multi
   import rob_multi_pkg::*;
#(
   parameter int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int DISP_W    = DISP_W_DEF,
   parameter int RET_W     = RET_W_DEF,
   parameter int CDB_W     = CDB_W_DEF,
   parameter int PR_W      = PR_W_DEF,
   parameter int IDX_W     = $clog2(ROB_DEPTH),
   parameter int DN_W      = $clog2(DISP_W + 1),
   parameter int RN_W      = $clog2(RET_W + 1)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DN_W-1:0]         id_dispatch_num,
   input  logic [DISP_W-1:0]       id_valid_inst,
   input  logic [DISP_W*PR_W-1:0]  fl_pr,
   input  logic [DISP_W*PR_W-1:0]  mt_told,
   input  logic [CDB_W-1:0]        cdb_pr_ready,
   input  logic [CDB_W*PR_W-1:0]   cdb_pr_tag,
`ifdef ROB_SQUASH_EN
   input  logic                    ex_squash,
`endif
   output logic [DN_W-1:0]         id_cap,
   output logic [DISP_W*IDX_W-1:0] id_rob_idx,
   output logic [RN_W-1:0]         fl_retire_num,
   output logic [RET_W*PR_W-1:0]   fl_retire_told,
   output logic [RET_W*PR_W-1:0]   amt_retire_tag,
   output logic [IDX_W:0]          rob_count,
   output logic                    rob_empty
);

   logic [ROB_DEPTH-1:0]      valid_q, valid_d, ready_q, ready_d;
   logic [ROB_DEPTH*PR_W-1:0] tag_q, tag_d, told_q, told_d;
   logic [IDX_W-1:0]          head_q, head_d, tail_q, tail_d;
   logic [IDX_W:0]            count_q, count_d;
   logic [ROB_DEPTH-1:0]      set_ready;
   logic [DN_W-1:0]           acc_num;
   logic                      squash;

`ifdef ROB_SQUASH_EN
   assign squash = ex_squash;
`else
   assign squash = 1'b0;
`endif

   rob_cdb_match #(
      .ROB_DEPTH (ROB_DEPTH),
      .CDB_W     (CDB_W),
      .PR_W      (PR_W)
   ) u_cdb_match (
      .pend_i      (valid_q & ~ready_q),
      .tag_i       (tag_q),
      .cdb_valid_i (cdb_pr_ready),
      .cdb_tag_i   (cdb_pr_tag),
      .set_ready_o (set_ready)
   );

   // Capacity comes from this cycle's occupancy only; a same-cycle retire does not raise it.
   always_comb begin
      id_cap  = DN_W'(min_int(ROB_DEPTH - int'(count_q), DISP_W));
      acc_num = squash ? '0 : DN_W'(min_int(int'(id_dispatch_num), int'(id_cap)));
      for (int k = 0; k < DISP_W; k++) begin
         id_rob_idx[k*IDX_W +: IDX_W] = tail_q + IDX_W'(k);
      end
   end

   always_comb begin : retire_scan
      logic             run;
      logic [IDX_W-1:0] idx;
      run            = ~squash;
      idx            = '0;
      fl_retire_num  = '0;
      fl_retire_told = '1;
      amt_retire_tag = '1;
      for (int k = 0; k < RET_W; k++) begin
         idx = head_q + IDX_W'(k);
         if (run && valid_q[idx] && ready_q[idx]) begin
            fl_retire_num                  = fl_retire_num + RN_W'(1);
            fl_retire_told[k*PR_W +: PR_W] = told_q[idx*PR_W +: PR_W];
            amt_retire_tag[k*PR_W +: PR_W] = tag_q[idx*PR_W +: PR_W];
         end else begin
            run = 1'b0;
         end
      end
   end

   // Order matters: CDB wakeup, then retire clear, then dispatch write.
   always_comb begin : next_state
      logic [IDX_W-1:0] idx;
      idx     = '0;
      valid_d = valid_q;
      ready_d = ready_q | set_ready;
      tag_d   = tag_q;
      told_d  = told_q;
      head_d  = head_q + IDX_W'(fl_retire_num);
      tail_d  = tail_q + IDX_W'(acc_num);
      count_d = count_q + (IDX_W+1)'(acc_num) - (IDX_W+1)'(fl_retire_num);
      for (int k = 0; k < RET_W; k++) begin
         if (RN_W'(k) < fl_retire_num) begin
            idx          = head_q + IDX_W'(k);
            valid_d[idx] = 1'b0;
            ready_d[idx] = 1'b0;
         end
      end
      for (int k = 0; k < DISP_W; k++) begin
         if (DN_W'(k) < acc_num) begin
            idx                       = tail_q + IDX_W'(k);
            valid_d[idx]              = 1'b1;
            ready_d[idx]              = ~id_valid_inst[k];
            tag_d[idx*PR_W +: PR_W]  = fl_pr[k*PR_W +: PR_W];
            told_d[idx*PR_W +: PR_W] = mt_told[k*PR_W +: PR_W];
         end
      end
      if (squash) begin
         valid_d = '0;
         ready_d = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         ready_q <= '0;
         tag_q   <= '0;
         told_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         ready_q <= ready_d;
         tag_q   <= tag_d;
         told_q  <= told_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign rob_count = count_q;
   assign rob_empty = (count_q == '0);

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed and randomized checks of rob_multi against a program-order queue model.
module tb_rob_multi;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  id_dispatch_num;
   logic [1:0]  id_valid_inst;
   logic [13:0] fl_pr, mt_told;
   logic [5:0]  cdb_pr_ready;
   logic [41:0] cdb_pr_tag;
   logic        ex_squash;
   logic [1:0]  id_cap;
   logic [11:0] id_rob_idx;
   logic [1:0]  fl_retire_num;
   logic [13:0] fl_retire_told, amt_retire_tag;
   logic [6:0]  rob_count;
   logic        rob_empty;

   always #5 clock = ~clock;

   rob_multi dut (
      .clock           (clock),
      .reset           (reset),
      .id_dispatch_num (id_dispatch_num),
      .id_valid_inst   (id_valid_inst),
      .fl_pr           (fl_pr),
      .mt_told         (mt_told),
      .cdb_pr_ready    (cdb_pr_ready),
      .cdb_pr_tag      (cdb_pr_tag),
`ifdef ROB_SQUASH_EN
      .ex_squash       (ex_squash),
`endif
      .id_cap          (id_cap),
      .id_rob_idx      (id_rob_idx),
      .fl_retire_num   (fl_retire_num),
      .fl_retire_told  (fl_retire_told),
      .amt_retire_tag  (amt_retire_tag),
      .rob_count       (rob_count),
      .rob_empty       (rob_empty)
   );

   // Reference model: live entries in program order, oldest first.
   typedef struct {
      logic [6:0] tag;
      logic [6:0] told;
      bit         rdy;
   } ent_t;

   ent_t mq[$];
   int   m_tail = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic int m_cap();
      return (64 - mq.size() < 2) ? 64 - mq.size() : 2;
   endfunction

   function automatic int m_ret();
      int r = 0;
      if (ex_squash) return 0;
      while (r < 2 && r < mq.size() && mq[r].rdy) r++;
      return r;
   endfunction

   task automatic check_all();
      int          r = m_ret();
      logic [13:0] et = '1;
      logic [13:0] eo = '1;
      logic [11:0] ei;
      for (int k = 0; k < r; k++) begin
         et[k*7 +: 7] = mq[k].tag;
         eo[k*7 +: 7] = mq[k].told;
      end
      for (int k = 0; k < 2; k++) ei[k*6 +: 6] = 6'((m_tail + k) % 64);
      chk("id_cap", id_cap, m_cap());
      chk("rob_count", rob_count, mq.size());
      chk("rob_empty", rob_empty, (mq.size() == 0));
      chk("fl_retire_num", fl_retire_num, r);
      chk("amt_retire_tag", amt_retire_tag, et);
      chk("fl_retire_told", fl_retire_told, eo);
      chk("id_rob_idx", id_rob_idx, ei);
   endtask

   task automatic model_step();
      int r = m_ret();
      int acc;
      if (reset || ex_squash) begin
         mq.delete();
         m_tail = 0;
      end else begin
         acc = (int'(id_dispatch_num) < m_cap()) ? int'(id_dispatch_num) : m_cap();
         for (int i = 0; i < mq.size(); i++)
            for (int c = 0; c < 6; c++)
               if (cdb_pr_ready[c] && cdb_pr_tag[c*7 +: 7] == mq[i].tag) mq[i].rdy = 1'b1;
         repeat (r) void'(mq.pop_front());
         for (int k = 0; k < acc; k++)
            mq.push_back('{tag: fl_pr[k*7 +: 7], told: mt_told[k*7 +: 7], rdy: !id_valid_inst[k]});
         m_tail = (m_tail + acc) % 64;
      end
   endtask

   task automatic cycle();
      #1;
      check_all();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      id_dispatch_num = '0;
      id_valid_inst   = '0;
      fl_pr           = '0;
      mt_told         = '0;
      cdb_pr_ready    = '0;
      cdb_pr_tag      = '0;
      ex_squash       = 1'b0;
   endtask

   task automatic set_disp(input int n, input logic [1:0] vi, input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] t0, input logic [6:0] t1);
      id_dispatch_num = 2'(n);
      id_valid_inst   = vi;
      fl_pr           = {p1, p0};
      mt_told         = {t1, t0};
   endtask

   task automatic set_cdb(input int ch, input logic [6:0] tag);
      cdb_pr_ready[ch]       = 1'b1;
      cdb_pr_tag[ch*7 +: 7]  = tag;
   endtask

   task automatic drain();
      int c;
      for (int n = 0; n < 200 && mq.size() != 0; n++) begin
         idle();
         c = 0;
         foreach (mq[i]) begin
            if (!mq[i].rdy && c < 6) begin
               set_cdb(c, mq[i].tag);
               c++;
            end
         end
         cycle();
      end
      idle();
      chk("drain_empty", rob_empty, 1'b1);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset and idle
      chk("rst_cap", id_cap, 2);
      chk("rst_empty", rob_empty, 1'b1);
      chk("rst_ret_num", fl_retire_num, 0);
      chk("rst_tag", amt_retire_tag, 14'h3fff);
      chk("rst_idx", id_rob_idx, {6'd1, 6'd0});
      cycle();

      // Fill to 64 with result-producing entries
      for (int i = 0; i < 32; i++) begin
         set_disp(2, 2'b11, 7'(2*i), 7'(2*i+1), 7'(64+2*i), 7'(65+2*i));
         cycle();
      end
      idle();
      chk("full_count", rob_count, 64);
      chk("full_cap", id_cap, 0);
      set_disp(2, 2'b11, 7'd100, 7'd101, 7'd1, 7'd2);
      cycle();
      idle();
      chk("drop_idx", id_rob_idx, {6'd1, 6'd0});
      chk("drop_count", rob_count, 64);

      // Full ROB: retire 2 with no dispatch
      set_cdb(0, 7'd0);
      set_cdb(1, 7'd1);
      cycle();
      idle();
      chk("full_ret_num", fl_retire_num, 2);
      cycle();
      chk("after_full_count", rob_count, 62);
      chk("after_full_cap", id_cap, 2);
      drain();

      // Out-of-order completion at head
      set_disp(2, 2'b11, 7'd10, 7'd11, 7'd40, 7'd41);
      cycle();
      set_disp(1, 2'b01, 7'd12, 7'd0, 7'd42, 7'd0);
      cycle();
      idle();
      set_cdb(0, 7'd12);
      cycle();
      idle();
      chk("ret_after12", fl_retire_num, 0);
      set_cdb(3, 7'd10);
      cycle();
      idle();
      chk("ret_after10", fl_retire_num, 1);
      chk("told_after10", fl_retire_told[6:0], 7'd40);
      cycle();
      set_cdb(5, 7'd11);
      cycle();
      idle();
      chk("ret_after11", fl_retire_num, 2);
      chk("tags_after11", amt_retire_tag, {7'd12, 7'd11});
      cycle();

      // Walk pointers to 62 with born-ready entries, then wrap
      for (int n = 0; n < 100 && m_tail != 62; n++) begin
         set_disp((62 - m_tail >= 2) ? 2 : 1, 2'b00, 7'($urandom_range(0, 127)),
                  7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
         cycle();
      end
      idle();
      for (int n = 0; n < 10 && mq.size() != 0; n++) cycle();
      set_disp(2, 2'b00, 7'd20, 7'd21, 7'd50, 7'd51);
      #1;
      chk("wrap_idx", id_rob_idx, {6'd63, 6'd62});
      cycle();
      idle();
      chk("wrap_tail", id_rob_idx, {6'd1, 6'd0});
      chk("wrap_ret_num", fl_retire_num, 2);
      chk("wrap_told", fl_retire_told, {7'd51, 7'd50});
      cycle();
      chk("wrap_empty", rob_count, 0);

      // Randomized traffic with one mid-run reset
      for (int i = 0; i < 400; i++) begin
         idle();
         set_disp($urandom_range(0, 2), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
                  7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
         for (int c = 0; c < 6; c++) begin
            if ($urandom_range(0, 2) == 0) begin
               if (mq.size() != 0 && $urandom_range(0, 3) != 0)
                  set_cdb(c, mq[$urandom_range(0, mq.size() - 1)].tag);
               else
                  set_cdb(c, 7'($urandom_range(0, 127)));
            end
         end
         reset = (i == 250);
         cycle();
         if (i == 250) chk("mid_reset_count", rob_count, 0);
      end
      reset = 1'b0;
      idle();
      cycle();

`ifdef ROB_SQUASH_EN
      // Squash at occupancy 40 with concurrent dispatch and ready head
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         set_disp(2, 2'b11, 7'(2*i), 7'(2*i+1), 7'(2*i), 7'(2*i+1));
         cycle();
      end
      idle();
      set_cdb(0, 7'd0);
      cycle();
      idle();
      chk("sq_pre_count", rob_count, 40);
      chk("sq_pre_ret", fl_retire_num, 1);
      ex_squash = 1'b1;
      set_disp(2, 2'b00, 7'd90, 7'd91, 7'd92, 7'd93);
      #1;
      chk("sq_ret_num", fl_retire_num, 0);
      cycle();
      idle();
      chk("sq_count", rob_count, 0);
      chk("sq_idx", id_rob_idx, {6'd1, 6'd0});
      set_disp(2, 2'b00, 7'd30, 7'd31, 7'd32, 7'd33);
      cycle();
      idle();
      cycle();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
